// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and single-outstanding instruction fetch
// sequencer. It walks RST -> REQ -> RSP -> EXEC, then back to REQ once the
// presented instruction retires.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When it is defined, a retire
// to a target that is not word aligned enters a sticky TRAP state. When it is
// undefined, the low two target bits are cleared and execution continues.
// Only XLEN = 32 is supported.
module pc_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            next_pc_src,
    input  logic [XLEN-1:0] target,
    input  logic            is_jalr,
    input  logic            retire,
    input  logic            stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [31:0]     instret,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_addr
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {S_RST, S_REQ, S_RSP, S_EXEC, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_RST, S_REQ, S_RSP, S_EXEC} state_t;
`endif

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            instr_valid_q;
    logic            req_valid_q;
    logic [31:0]     instret_q;
    logic [XLEN-1:0] tgt_eff;
    logic [XLEN-1:0] nxt_d;

    // Next-PC selection; JALR clears bit 0 before any alignment test.
    always_comb begin
        tgt_eff = is_jalr ? {target[XLEN-1:1], 1'b0} : target;
        nxt_d   = next_pc_src ? tgt_eff : pc_q + XLEN'(4);
`ifndef PC_MISALIGN_TRAP_EN
        nxt_d[1:0] = 2'b00;
`endif
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            trap_q;
    logic [XLEN-1:0] trap_addr_q;
`endif

    // Fetch FSM. Every output is registered here and is set on the state
    // transition, so the outputs are valid on the first cycle of each state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RST;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b0;
            instret_q     <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
            trap_addr_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_RST: begin
                    state_q     <= S_REQ;
                    req_valid_q <= 1'b1;
                end
                S_REQ: begin
                    // The address is pc_q, which cannot change while in REQ.
                    if (imem_req_ready) begin
                        state_q     <= S_RSP;
                        req_valid_q <= 1'b0;
                    end
                end
                S_RSP: begin
                    // rsp_valid is only sampled from the cycle after
                    // acceptance, which keeps one request in flight.
                    if (imem_rsp_valid) begin
                        instr_q       <= imem_rsp_data;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // stall takes priority over retire.
                    if (!stall && retire) begin
                        instret_q     <= instret_q + 32'd1;
                        instr_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                        if (nxt_d[1:0] != 2'b00) begin
                            state_q     <= S_TRAP;
                            trap_q      <= 1'b1;
                            trap_addr_q <= nxt_d;
                        end else begin
                            pc_q        <= nxt_d;
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
`else
                        pc_q        <= nxt_d;
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
`endif
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                S_TRAP: begin
                    // Sticky until reset; no requests are issued.
                    state_q <= S_TRAP;
                end
`endif
                default: begin
                    state_q     <= S_RST;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign instret        = instret_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_trap  = trap_q;
    assign trap_addr      = trap_addr_q;
`else
    assign misalign_trap  = 1'b0;
    assign trap_addr      = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of retire vectors with fetch
// timing, plus hand-written stall, mid-fetch reset and misaligned-JALR cases.
// Fetched data is queued when the response is driven and compared when
// instr_valid rises.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_pc_src = 1'b0;
    logic [31:0] target = '0;
    logic        is_jalr = 1'b0;
    logic        retire = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] pc, pc_plus4, instr, instret, trap_addr;
    logic        instr_valid, misalign_trap;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];
    logic [31:0] pc_exp;
    logic [31:0] ret_exp;

    typedef struct {
        logic        src;
        logic        jalr;
        logic [31:0] tgt;
        int          rdly;
        int          sdly;
        logic [31:0] data;
        logic [31:0] nxt;
    } vec_t;
    vec_t vecs[10];

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .next_pc_src(next_pc_src), .target(target),
        .is_jalr(is_jalr), .retire(retire), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .pc(pc), .pc_plus4(pc_plus4),
        .instr(instr), .instr_valid(instr_valid), .instret(instret),
        .misalign_trap(misalign_trap), .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
        chk({tag, "_instret"}, instret, 32'h0);
        chk({tag, "_trap"}, {31'b0, misalign_trap}, 32'h0);
        chk({tag, "_trap_addr"}, trap_addr, 32'h0);
    endtask

    // Fetch one instruction at addr; the DUT must end up in EXEC holding data.
    task automatic do_fetch(input logic [31:0] addr, input int rdly, input int sdly,
                            input logic [31:0] data);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'b0, imem_req_valid}, 32'h1);
        chk("req_addr", imem_req_addr, addr);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready = 1'b0;
            @(negedge clk);
            chk("req_hold_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("req_hold_addr", imem_req_addr, addr);
        end
        // A response in the acceptance cycle must be ignored.
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~data;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("req_drop", {31'b0, imem_req_valid}, 32'h0);
        chk("early_rsp_ignored", {31'b0, instr_valid}, 32'h0);
        for (int i = 0; i < sdly; i++) begin
            @(negedge clk);
            chk("rsp_wait_invalid", {31'b0, instr_valid}, 32'h0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb.push_back(data);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        chk("instr_valid", {31'b0, instr_valid}, 32'h1);
        if (instr_valid && sb.size() > 0) chk("instr", instr, sb.pop_front());
    endtask

    // Retire the presented instruction with the given branch decision.
    task automatic do_retire(input logic src, input logic jalr, input logic [31:0] tgt);
        next_pc_src = src;
        is_jalr     = jalr;
        target      = tgt;
        retire      = 1'b1;
        @(negedge clk);
        retire      = 1'b0;
        next_pc_src = 1'b0;
        is_jalr     = 1'b0;
        ret_exp     = ret_exp + 32'd1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0013, 32'h0000_0004};
        vecs[1] = '{1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0013, 32'h0000_0008};
        vecs[2] = '{1'b0, 1'b0, 32'h0,         0, 0, 32'h0000_0013, 32'h0000_000C};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0100, 1, 2, 32'h1111_2222, 32'h0000_0100};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 5, 3, 32'hDEAD_BEEF, 32'h0000_0040};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0081, 0, 1, 32'h0000_8067, 32'h0000_0080};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0123, 2, 0, 32'hA5A5_5A5A, 32'h0000_0084};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 0, 0, 32'h0F0F_F0F0, 32'hFFFF_FFFC};
        vecs[8] = '{1'b0, 1'b0, 32'h0,         1, 1, 32'h1234_5678, 32'h0000_0000};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_1001, 0, 0, 32'h0BAD_F00D, 32'h0000_1000};

        // Reset values, then one RST cycle without a request.
        pc_exp  = 32'h0;
        ret_exp = 32'h0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_state_no_req", {31'b0, imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("req_after_rst", {31'b0, imem_req_valid}, 32'h1);

        for (int v = 0; v < 10; v++) begin
            do_fetch(pc_exp, vecs[v].rdly, vecs[v].sdly, vecs[v].data);
            chk("exec_pc", pc, pc_exp);
            chk("exec_pc_plus4", pc_plus4, pc_exp + 32'd4);
            chk("exec_instret", instret, ret_exp);
            do_retire(vecs[v].src, vecs[v].jalr, vecs[v].tgt);
            pc_exp = vecs[v].nxt;
            chk("retire_pc", pc, pc_exp);
            chk("retire_instret", instret, ret_exp);
            chk("retire_instr_valid", {31'b0, instr_valid}, 32'h0);
        end

        // Stall held with retire: nothing moves, and a stray response is ignored.
        do_fetch(pc_exp, 0, 0, 32'h0000_0073);
        stall       = 1'b1;
        retire      = 1'b1;
        next_pc_src = 1'b1;
        target      = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hFFFF_0000 | i;
            @(negedge clk);
            chk("stall_pc", pc, pc_exp);
            chk("stall_instret", instret, ret_exp);
            chk("stall_instr", instr, 32'h0000_0073);
            chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
        end
        imem_rsp_valid = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        retire      = 1'b0;
        next_pc_src = 1'b0;
        ret_exp     = ret_exp + 32'd1;
        pc_exp      = 32'h0000_0300;
        chk("unstall_pc", pc, pc_exp);
        chk("unstall_instret", instret, ret_exp);
        chk("unstall_req_addr", imem_req_addr, pc_exp);

        // Asynchronous reset while waiting in RSP; the late response is ignored.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("late_rsp_ignored", {31'b0, instr_valid}, 32'h0);
        chk("restart_req", {31'b0, imem_req_valid}, 32'h1);
        chk("restart_addr", imem_req_addr, 32'h0);
        pc_exp  = 32'h0;
        ret_exp = 32'h0;

        // JALR to 0x203: bit 0 cleared gives 0x202.
        do_fetch(pc_exp, 0, 0, 32'h0000_8067);
        do_retire(1'b1, 1'b1, 32'h0000_0203);
        chk("jalr_instret", instret, ret_exp);
        chk("jalr_instr_valid", {31'b0, instr_valid}, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("trap_flag", {31'b0, misalign_trap}, 32'h1);
        chk("trap_addr", trap_addr, 32'h0000_0202);
        chk("trap_pc_held", pc, 32'h0);
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("trap_no_req", {31'b0, imem_req_valid}, 32'h0);
            chk("trap_sticky", {31'b0, misalign_trap}, 32'h1);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
`else
        chk("notrap_flag", {31'b0, misalign_trap}, 32'h0);
        chk("notrap_addr", trap_addr, 32'h0);
        chk("notrap_pc", pc, 32'h0000_0200);
        do_fetch(32'h0000_0200, 0, 0, 32'h0000_0013);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
